cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 tb/tb_cdb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Result broadcast bus arbiter: two producers (ALU, load/store buffer), each backed
// by a small FIFO, share one registered broadcast using round-robin arbitration.
module cdb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ROB_TAG_W = 4,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_misbranch,
    input  logic [ROB_TAG_W-1:0] in_alu_reorder,
    input  logic [DATA_W-1:0]    in_alu_value,
    output logic                 out_alu_stall,
    input  logic [ROB_TAG_W-1:0] in_lsb_reorder,
    input  logic [DATA_W-1:0]    in_lsb_value,
    output logic                 out_lsb_stall,
    output logic [ROB_TAG_W-1:0] out_cdb_reorder,
    output logic [DATA_W-1:0]    out_cdb_value
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ALU   = 0;
    localparam int LSB   = 1;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSB = 1'b1
    } grant_t;

    logic [ROB_TAG_W-1:0] tag_mem [2][DEPTH];
    logic [DATA_W-1:0]    val_mem [2][DEPTH];
    logic [PTR_W-1:0]     rd_ptr  [2];
    logic [PTR_W-1:0]     wr_ptr  [2];
    logic [CNT_W-1:0]     count   [2];
    grant_t               last_grant;

    logic [ROB_TAG_W-1:0] in_tag [2];
    logic [DATA_W-1:0]    in_val [2];
    logic [1:0]           full, has_head, accept, cand, win, push, pop;
    logic [ROB_TAG_W-1:0] win_tag;
    logic [DATA_W-1:0]    win_val;

    assign in_tag[ALU] = in_alu_reorder;
    assign in_tag[LSB] = in_lsb_reorder;
    assign in_val[ALU] = in_alu_value;
    assign in_val[LSB] = in_lsb_value;

    assign out_alu_stall = full[ALU];
    assign out_lsb_stall = full[LSB];

    // A source's candidate is its FIFO head when one exists, otherwise the incoming bypass.
    always_comb begin
        full     = '0;
        has_head = '0;
        accept   = '0;
        cand     = '0;
        push     = '0;
        pop      = '0;
        win_tag  = '0;
        win_val  = '0;
        for (int s = 0; s < 2; s++) begin
            full[s]     = (count[s] == CNT_W'(DEPTH));
            has_head[s] = (count[s] != '0);
            accept[s]   = (in_tag[s] != '0) && !full[s] && rdy && !in_misbranch;
            cand[s]     = has_head[s] || accept[s];
        end
        win[ALU] = cand[ALU] && (!cand[LSB] || (last_grant == GRANT_LSB));
        win[LSB] = cand[LSB] && (!cand[ALU] || (last_grant == GRANT_ALU));
        for (int s = 0; s < 2; s++) begin
            pop[s]  = win[s] && has_head[s];
            push[s] = accept[s] && !(win[s] && !has_head[s]);
            if (win[s]) begin
                win_tag = has_head[s] ? tag_mem[s][rd_ptr[s]] : in_tag[s];
                win_val = has_head[s] ? val_mem[s][rd_ptr[s]] : in_val[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                tag_mem[s][wr_ptr[s]] <= in_tag[s];
                val_mem[s][wr_ptr[s]] <= in_val[s];
            end
        end
    end

    // Misbranch outranks everything else, but only while the block is not frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            last_grant      <= GRANT_LSB;
            out_cdb_reorder <= '0;
            out_cdb_value   <= '0;
        end else if (rdy) begin
            if (in_misbranch) begin
                for (int s = 0; s < 2; s++) begin
                    rd_ptr[s] <= '0;
                    wr_ptr[s] <= '0;
                    count[s]  <= '0;
                end
                out_cdb_reorder <= '0;
                out_cdb_value   <= '0;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                    if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                    count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
                end
                out_cdb_reorder <= win_tag;
                out_cdb_value   <= win_val;
                if (win[ALU])
                    last_grant <= GRANT_ALU;
                else if (win[LSB])
                    last_grant <= GRANT_LSB;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single request, contention, streaming with
// backpressure, misbranch flush and rdy freeze, all against hand-computed values.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        in_misbranch = 1'b0;
    logic [3:0]  in_alu_reorder = '0;
    logic [31:0] in_alu_value = '0;
    logic        out_alu_stall;
    logic [3:0]  in_lsb_reorder = '0;
    logic [31:0] in_lsb_value = '0;
    logic        out_lsb_stall;
    logic [3:0]  out_cdb_reorder;
    logic [31:0] out_cdb_value;

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(.DATA_W(32), .ROB_TAG_W(4), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .in_misbranch    (in_misbranch),
        .in_alu_reorder  (in_alu_reorder),
        .in_alu_value    (in_alu_value),
        .out_alu_stall   (out_alu_stall),
        .in_lsb_reorder  (in_lsb_reorder),
        .in_lsb_value    (in_lsb_value),
        .out_lsb_stall   (out_lsb_stall),
        .out_cdb_reorder (out_cdb_reorder),
        .out_cdb_value   (out_cdb_value)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a_tag, input logic [31:0] a_val,
                                 input logic [3:0] l_tag, input logic [31:0] l_val,
                                 input logic misb, input logic rdy_v);
        in_alu_reorder = a_tag;
        in_alu_value   = a_val;
        in_lsb_reorder = l_tag;
        in_lsb_value   = l_val;
        in_misbranch   = misb;
        rdy            = rdy_v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBus(input string name, input logic [3:0] tag, input logic [31:0] val);
        checkOutput({name, "_tag"}, 32'(out_cdb_reorder), 32'(tag));
        checkOutput({name, "_val"}, out_cdb_value, val);
    endtask

    task automatic doReset();
        in_alu_reorder = '0;
        in_lsb_reorder = '0;
        in_misbranch   = 1'b0;
        rdy            = 1'b1;
        rst            = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] valOf(input logic [3:0] tag);
        if (tag == 0)
            return 32'h0;
        else if (tag < 9)
            return 32'hA000 + 32'(tag);
        else
            return 32'hB000 + 32'(tag);
    endfunction

    logic [3:0] alu_seq [5]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [3:0] lsb_seq [4]  = '{4'd9, 4'd10, 4'd11, 4'd12};
    logic [3:0] exp_tag [10] = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11, 4'd4, 4'd12, 4'd5, 4'd0};
    logic       exp_sa  [10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    logic       exp_sl  [10] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0] a_t, l_t;
        logic       sa, sl;
        int         ai, li;

        // Reset values, idle bus after release, async reset mid-broadcast
        @(posedge clk);
        #1;
        checkBus("reset", 4'd0, 32'h0);
        checkOutput("reset_alu_stall", 32'(out_alu_stall), 32'd0);
        checkOutput("reset_lsb_stall", 32'(out_lsb_stall), 32'd0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkBus("idle1", 4'd0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkBus("idle2", 4'd0, 32'h0);
        applyStimulus(4'd5, 32'h55, 0, 0, 0, 1);
        checkBus("pre_async", 4'd5, 32'h55);
        #3;
        rst = 1'b0;
        #1;
        checkBus("async_reset", 4'd0, 32'h0);
        checkOutput("async_alu_stall", 32'(out_alu_stall), 32'd0);
        checkOutput("async_lsb_stall", 32'(out_lsb_stall), 32'd0);

        // Single request
        doReset();
        applyStimulus(4'd3, 32'h11, 0, 0, 0, 1);
        checkBus("single", 4'd3, 32'h11);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkBus("single_after", 4'd0, 32'h0);

        // Contention: ALU wins the first tie, LSB follows from its FIFO
        doReset();
        applyStimulus(4'd1, 32'hA, 4'd2, 32'hB, 0, 1);
        checkBus("cont1", 4'd1, 32'hA);
        checkOutput("cont1_lsb_stall", 32'(out_lsb_stall), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkBus("cont2", 4'd2, 32'hB);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkBus("cont3", 4'd0, 32'h0);

        // Streaming with backpressure; producers hold while stalled
        doReset();
        ai = 0;
        li = 0;
        for (int c = 0; c < 10; c++) begin
            a_t = (ai < 5) ? alu_seq[ai] : 4'd0;
            l_t = (li < 4) ? lsb_seq[li] : 4'd0;
            sa  = out_alu_stall;
            sl  = out_lsb_stall;
            applyStimulus(a_t, valOf(a_t), l_t, valOf(l_t), 0, 1);
            if (a_t != 0 && !sa) ai++;
            if (l_t != 0 && !sl) li++;
            checkBus($sformatf("stream%0d", c), exp_tag[c], valOf(exp_tag[c]));
            checkOutput($sformatf("stream%0d_alu_stall", c), 32'(out_alu_stall), 32'(exp_sa[c]));
            checkOutput($sformatf("stream%0d_lsb_stall", c), 32'(out_lsb_stall), 32'(exp_sl[c]));
        end
        checkOutput("stream_alu_consumed", 32'(ai), 32'd5);
        checkOutput("stream_lsb_consumed", 32'(li), 32'd4);

        // Misbranch with ALU FIFO holding 2 and LSB FIFO holding 1
        doReset();
        applyStimulus(4'd1, valOf(4'd1), 4'd9, valOf(4'd9), 0, 1);
        checkBus("mb_fill1", 4'd1, valOf(4'd1));
        applyStimulus(4'd2, valOf(4'd2), 4'd10, valOf(4'd10), 0, 1);
        checkBus("mb_fill2", 4'd9, valOf(4'd9));
        applyStimulus(4'd3, valOf(4'd3), 0, 0, 0, 1);
        checkBus("mb_fill3", 4'd2, valOf(4'd2));
        applyStimulus(4'd4, valOf(4'd4), 4'd11, valOf(4'd11), 0, 1);
        checkBus("mb_fill4", 4'd10, valOf(4'd10));
        checkOutput("mb_fill_alu_stall", 32'(out_alu_stall), 32'd1);
        checkOutput("mb_fill_lsb_stall", 32'(out_lsb_stall), 32'd0);
        applyStimulus(4'd7, valOf(4'd7), 4'd13, valOf(4'd13), 1, 1);
        checkBus("mb_flush", 4'd0, 32'h0);
        checkOutput("mb_alu_stall", 32'(out_alu_stall), 32'd0);
        checkOutput("mb_lsb_stall", 32'(out_lsb_stall), 32'd0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            checkBus($sformatf("mb_after%0d", c), 4'd0, 32'h0);
        end
        applyStimulus(4'd8, valOf(4'd8), 0, 0, 0, 1);
        checkBus("mb_bypass", 4'd8, valOf(4'd8));

        // Freeze: rdy low holds everything and ignores misbranch
        doReset();
        applyStimulus(4'd4, 32'h44, 0, 0, 0, 1);
        checkBus("frz_start", 4'd4, 32'h44);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'd6, 32'h66, 0, 0, (c == 1), 0);
            checkBus($sformatf("frz_hold%0d", c), 4'd4, 32'h44);
        end
        applyStimulus(4'd6, 32'h66, 0, 0, 0, 1);
        checkBus("frz_release", 4'd6, 32'h66);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkBus("frz_idle", 4'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
